sigma_delta_tx_beamformer: RTL and testbench
============================================

# sigma_delta_tx_beamformer

Transmit-side counterpart of the sigma-delta receive beamformer. Converts one multi-bit signed sample stream into a 1-bit first-order sigma-delta stream and writes it into a shared delay line. Each of NUM_CH channels then taps that line at its own programmed delay, with optional inversion. The per-channel 1-bit outputs drive the array elements. Delay and invert settings are loaded through a valid/ready handshake and take effect atomically on a sample boundary.

## Interface
- NUM_CH, 64: number of output channels
- ADDR_WIDTH, 8: delay-line address width; depth DEPTH = 2^ADDR_WIDTH samples
- IN_WIDTH, 16: width of signed input sample; FS = 2^(IN_WIDTH-1)

- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- sample  in  1  sample strobe; the modulator and delay line advance only when high
- dataIn  in  IN_WIDTH  signed input sample, consumed on the strobe cycle
- cmdIn  in  NUM_CH*ADDR_WIDTH  per-channel delay in samples; channel k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- invertBit  in  NUM_CH  per-channel invert: 1 inverts, 0 passes through
- cmdValid  in  1  cmdIn/invertBit valid
- cmdReady  out  1  block can accept a command set
- cmdApplied  out  1  one-cycle pulse when a shadowed set becomes active
- modBit  out  1  current modulator output bit
- dataOut  out  NUM_CH  per-channel delayed, optionally inverted bits

## Operation
- Modulator state:
  - acc: signed, IN_WIDTH+2 bits.
  - fb = +FS if modBit = 1, else -FS.
  - On a strobe, accNew = acc + sext(dataIn) - fb; acc <= accNew; modBit <= (accNew >= 0).
  - No saturation. acc stays in [-2FS, 2FS) for every legal dataIn.
- Delay line:
  - DEPTH-bit shift register, line[0] newest.
  - On a strobe, line <= {line[DEPTH-2:0], (accNew >= 0)}. The new bit lands in line[0] on the same edge as modBit.
- Tap:
  - Every cycle, dataOut[k] <= line[delayAct[k]] ^ invAct[k].
  - Delay d selects the bit produced d strobes before the most recent one. Valid d range is 0..DEPTH-1; there are no illegal values.
- Command path:
  - Shadow registers delaySh and invSh, active registers delayAct and invAct, and a pending flag.
  - cmdReady = ~pending.
  - Accept when cmdValid && cmdReady: capture cmdIn and invertBit into the shadow registers; pending <= 1.
  - On a strobe with pending = 1: active <= shadow; pending <= 0; cmdApplied <= 1 for one cycle.
  - An accept and a strobe in the same cycle: the set is shadowed and is NOT applied on that strobe; it applies on the next strobe.
  - While pending, cmdValid is ignored. The shadowed set is never overwritten.
- Reset values:
  - acc = 0, modBit = 0, line = all 0.
  - delayAct = 0, invAct = 0, shadow registers = 0.
  - pending = 0, so cmdReady = 1 after reset.
  - cmdApplied = 0, dataOut = 0.
  - A reset while a set is pending discards the set.

## Timing
- Strobe sampled at edge E:
  - modBit and line[0] hold the new bit after E.
  - dataOut reflects that bit (d = 0) after E+1.
  - Latency from dataIn to dataOut is 2 edges plus d strobes.
- Active settings change at strobe edge E. dataOut uses them from E+1, together with the new sample. No output ever mixes old and new settings within one sample.
- cmdApplied is high in the cycle after E. cmdReady is high from the cycle after E.
- Without strobes, dataOut and modBit hold their values.
- Back-to-back strobes (every cycle) are legal. Throughput is 1 sample per clock.

## Test plan
- Reset, then dataIn = 0 with a strobe every cycle -> modBit sequence 1,1,0,1,0,1,0,… (alternating after the 2nd sample); acc stays within [-FS, FS].
- dataIn = FS/2 constant for 1024 strobes -> count of 1s in modBit = 768 ± 2; dataIn = -FS -> all modBit = 0 after the first strobe.
- Apply the set with channel 0 at d = 0, channel 1 at d = 5 with inversion, channel 2 at d = DEPTH-1. Drive a single 1 (impulse pattern via dataIn) -> channel 0 rises 2 edges after the strobe; channel 1 shows the inverted copy 5 strobes later; channel 2 shows it DEPTH-1 strobes later.
- cmdValid asserted with no strobe for 10 cycles -> accepted once, cmdReady low, a second set ignored. On the next strobe, active = first set, cmdApplied pulses once, cmdReady returns high the following cycle.
- Accept coincident with a strobe -> settings are unchanged on that strobe and applied on the next one; assert reset while pending -> cmdReady = 1, dataOut = 0, old delays = 0 after reset.

Source files
------------

// File: rtl/sigma_delta_tx_beamformer_if.sv
// sigma_delta_tx_beamformer_if: command handshake bundle carrying per-channel delay/invert sets
interface sigma_delta_tx_beamformer_if #(
  parameter int NUM_CH = 64,
  parameter int ADDR_WIDTH = 8
);
  logic [NUM_CH*ADDR_WIDTH-1:0] cmdIn;
  logic [NUM_CH-1:0] invertBit;
  logic cmdValid;
  logic cmdReady;
  logic cmdApplied;
  modport master(output cmdIn, invertBit, cmdValid, input cmdReady, cmdApplied);
  modport slave(input cmdIn, invertBit, cmdValid, output cmdReady, cmdApplied);
endinterface

// File: rtl/sigma_delta_tx_beamformer.sv
// sigma_delta_tx_beamformer: first-order sigma-delta modulator feeding a shared delay line tapped per channel
module sigma_delta_tx_beamformer #(
  parameter int NUM_CH = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int IN_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic [IN_WIDTH-1:0] dataIn,
  sigma_delta_tx_beamformer_if.slave cmd,
  output logic modBit,
  output logic [NUM_CH-1:0] dataOut
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int AW = IN_WIDTH + 2;
  localparam logic [AW-1:0] FS = AW'(1) << (IN_WIDTH - 1);
  logic [AW-1:0] acc, accNew;
  logic newBit;
  logic [DEPTH-1:0] line;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] delaySh, delayAct;
  logic [NUM_CH-1:0] invSh, invAct;
  logic pending;
  // two's-complement wraparound is harmless: acc is bounded to [-2FS, 2FS) by construction
  assign accNew = acc + {{2{dataIn[IN_WIDTH-1]}}, dataIn} + (modBit ? -FS : FS);
  assign newBit = ~accNew[AW-1];
  assign cmd.cmdReady = ~pending;
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      modBit <= 1'b0;
      line <= '0;
    end else if (sample) begin
      acc <= accNew;
      modBit <= newBit;
      line <= {line[DEPTH-2:0], newBit};
    end
  end
  // a set accepted on a strobe cycle only becomes pending, so it applies on the following strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      delaySh <= '0;
      invSh <= '0;
      delayAct <= '0;
      invAct <= '0;
      pending <= 1'b0;
      cmd.cmdApplied <= 1'b0;
    end else begin
      cmd.cmdApplied <= sample && pending;
      if (sample && pending) begin
        delayAct <= delaySh;
        invAct <= invSh;
        pending <= 1'b0;
      end else if (cmd.cmdValid && !pending) begin
        delaySh <= cmd.cmdIn;
        invSh <= cmd.invertBit;
        pending <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) dataOut <= '0;
    else for (int k = 0; k < NUM_CH; k++) dataOut[k] <= line[delayAct[k]] ^ invAct[k];
  end
endmodule

// File: tb/tb_sigma_delta_tx_beamformer.sv
// tb_sigma_delta_tx_beamformer: randomized self-checking bench against a bit-history reference model
module tb_sigma_delta_tx_beamformer;
  localparam int NUM_CH = 64, AW = 8, IW = 16, DEPTH = 256, FS = 32768;
  logic clk = 0, rst = 1, sample = 0;
  logic [IW-1:0] dataIn = '0;
  logic modBit;
  logic [NUM_CH-1:0] dataOut;
  int checks = 0, fails = 0;
  sigma_delta_tx_beamformer_if #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW)) cif();
  sigma_delta_tx_beamformer #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .IN_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .sample(sample), .dataIn(dataIn), .cmd(cif), .modBit(modBit), .dataOut(dataOut)
  );
  always #5 clk = ~clk;
  bit hist[$];
  int macc;
  bit mmod, mpend, expApplied;
  int mDel[NUM_CH], mShDel[NUM_CH];
  bit [NUM_CH-1:0] mInv, mShInv;
  logic [NUM_CH-1:0] expOut;
  task automatic model_reset();
    hist.delete();
    repeat (DEPTH) hist.push_back(1'b0);
    macc = 0; mmod = 0; mpend = 0; expApplied = 0; expOut = '0; mInv = '0; mShInv = '0;
    for (int k = 0; k < NUM_CH; k++) begin mDel[k] = 0; mShDel[k] = 0; end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; sample = 0; cif.cmdValid = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
  endtask
  task automatic rand_cmd();
    for (int k = 0; k < NUM_CH; k++) cif.cmdIn[k*AW +: AW] = AW'($urandom);
    cif.invertBit = {$urandom, $urandom};
  endtask
  // one clock: drive inputs, advance the model by the rules, return 1ns after the edge
  task automatic step(input bit s, input logic [IW-1:0] d, input bit v);
    bit acceptNow;
    @(negedge clk);
    sample = s; dataIn = d; cif.cmdValid = v;
    for (int k = 0; k < NUM_CH; k++) expOut[k] = hist[mDel[k]] ^ mInv[k];
    expApplied = s && mpend;
    acceptNow = v && !mpend;
    if (s && mpend) begin mDel = mShDel; mInv = mShInv; mpend = 0; end
    if (acceptNow) begin
      for (int k = 0; k < NUM_CH; k++) mShDel[k] = int'(cif.cmdIn[k*AW +: AW]);
      mShInv = cif.invertBit;
      mpend = 1;
    end
    if (s) begin
      macc = macc + int'($signed(d)) - (mmod ? FS : -FS);
      mmod = macc >= 0;
      hist.push_front(mmod);
      void'(hist.pop_back());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (modBit !== 1'b0) begin fails++; $display("FAIL reset_modBit: got %b want 0", modBit); end
    checks++; if (dataOut !== '0) begin fails++; $display("FAIL reset_dataOut: got %h want 0", dataOut); end
    checks++; if (cif.cmdReady !== 1'b1) begin fails++; $display("FAIL reset_cmdReady: got %b want 1", cif.cmdReady); end
    checks++; if (cif.cmdApplied !== 1'b0) begin fails++; $display("FAIL reset_cmdApplied: got %b want 0", cif.cmdApplied); end
  endtask
  task automatic test_zero_input();
    int a;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(1, '0, 0);
      a = $signed(dut.acc);
      checks++; if (modBit !== ((i < 2) ? 1'b1 : 1'(i % 2))) begin fails++; $display("FAIL zero_seq[%0d]: got %b want %b", i, modBit, (i < 2) ? 1'b1 : 1'(i % 2)); end
      checks++; if (a < -FS || a > FS) begin fails++; $display("FAIL zero_acc_range[%0d]: got %0d want within +-%0d", i, a, FS); end
      checks++; if (dataOut !== expOut) begin fails++; $display("FAIL zero_dataOut[%0d]: got %h want %h", i, dataOut, expOut); end
    end
  endtask
  task automatic test_half_scale();
    int ones = 0;
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      step(1, IW'(FS / 2), 0);
      ones += int'(modBit);
      checks++; if (modBit !== mmod) begin fails++; $display("FAIL half_mod[%0d]: got %b want %b", i, modBit, mmod); end
    end
    checks++; if (ones < 766 || ones > 770) begin fails++; $display("FAIL half_density: got %0d ones want 768+-2", ones); end
    do_reset();
    for (int i = 0; i < 50; i++) begin
      step(1, 16'h8000, 0);
      checks++; if (i > 0 && modBit !== 1'b0) begin fails++; $display("FAIL negfs_mod[%0d]: got %b want 0", i, modBit); end
    end
  endtask
  task automatic test_taps();
    do_reset();
    cif.cmdIn = '0; cif.invertBit = '0;
    cif.cmdIn[1*AW +: AW] = 8'd5; cif.cmdIn[2*AW +: AW] = 8'(DEPTH - 1); cif.invertBit[1] = 1'b1;
    step(0, '0, 1);
    step(1, 16'h8000, 0);
    checks++; if (cif.cmdApplied !== 1'b1) begin fails++; $display("FAIL taps_applied: got %b want 1", cif.cmdApplied); end
    for (int i = 0; i < 360; i++) begin
      step(i % 7 != 6, (i == 10 || i == 11) ? 16'h7FFF : 16'h8000, 0);
      checks++; if (dataOut !== expOut) begin fails++; $display("FAIL taps_dataOut[%0d]: got %h want %h", i, dataOut, expOut); end
      checks++; if (modBit !== mmod) begin fails++; $display("FAIL taps_mod[%0d]: got %b want %b", i, modBit, mmod); end
    end
  endtask
  task automatic test_cmd_hold();
    do_reset();
    rand_cmd();
    step(0, '0, 1);
    for (int i = 0; i < 9; i++) begin
      rand_cmd();
      step(0, '0, 1);
      checks++; if (cif.cmdReady !== 1'b0) begin fails++; $display("FAIL hold_ready[%0d]: got %b want 0", i, cif.cmdReady); end
      checks++; if (cif.cmdApplied !== 1'b0) begin fails++; $display("FAIL hold_applied[%0d]: got %b want 0", i, cif.cmdApplied); end
    end
    step(1, IW'($urandom), 0);
    checks++; if (cif.cmdApplied !== 1'b1) begin fails++; $display("FAIL hold_apply_pulse: got %b want 1", cif.cmdApplied); end
    checks++; if (cif.cmdReady !== 1'b1) begin fails++; $display("FAIL hold_ready_back: got %b want 1", cif.cmdReady); end
    for (int i = 0; i < 300; i++) begin
      step(1, IW'($urandom), 0);
      checks++; if (cif.cmdApplied !== 1'b0) begin fails++; $display("FAIL hold_single_pulse[%0d]: got %b want 0", i, cif.cmdApplied); end
      checks++; if (dataOut !== expOut) begin fails++; $display("FAIL hold_dataOut[%0d]: got %h want %h", i, dataOut, expOut); end
    end
  endtask
  task automatic test_coincident();
    do_reset();
    for (int i = 0; i < 20; i++) step(1, IW'($urandom), 0);
    rand_cmd();
    step(1, IW'($urandom), 1);
    checks++; if (cif.cmdApplied !== 1'b0) begin fails++; $display("FAIL coin_no_apply: got %b want 0", cif.cmdApplied); end
    checks++; if (cif.cmdReady !== 1'b0) begin fails++; $display("FAIL coin_pending: got %b want 0", cif.cmdReady); end
    step(1, IW'($urandom), 0);
    checks++; if (dataOut !== expOut) begin fails++; $display("FAIL coin_old_settings: got %h want %h", dataOut, expOut); end
    checks++; if (cif.cmdApplied !== 1'b1) begin fails++; $display("FAIL coin_apply_next: got %b want 1", cif.cmdApplied); end
    for (int i = 0; i < 5; i++) begin
      step(1, IW'($urandom), 0);
      checks++; if (dataOut !== expOut) begin fails++; $display("FAIL coin_dataOut[%0d]: got %h want %h", i, dataOut, expOut); end
    end
    rand_cmd();
    step(0, '0, 1);
    checks++; if (cif.cmdReady !== 1'b0) begin fails++; $display("FAIL rstpend_pending: got %b want 0", cif.cmdReady); end
    do_reset();
    checks++; if (cif.cmdReady !== 1'b1) begin fails++; $display("FAIL rstpend_ready: got %b want 1", cif.cmdReady); end
    checks++; if (dataOut !== '0) begin fails++; $display("FAIL rstpend_dataOut: got %h want 0", dataOut); end
    for (int i = 0; i < 8; i++) begin
      step(1, IW'($urandom), 0);
      checks++; if (cif.cmdApplied !== 1'b0) begin fails++; $display("FAIL rstpend_applied[%0d]: got %b want 0", i, cif.cmdApplied); end
      checks++; if (dataOut !== expOut) begin fails++; $display("FAIL rstpend_dataOut[%0d]: got %h want %h", i, dataOut, expOut); end
    end
  endtask
  task automatic test_random();
    bit s, v;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      s = $urandom_range(0, 3) != 0;
      v = $urandom_range(0, 4) == 0;
      if (v) rand_cmd();
      step(s, IW'($urandom), v);
      checks++; if (dataOut !== expOut) begin fails++; $display("FAIL rand_dataOut[%0d]: got %h want %h", i, dataOut, expOut); end
      checks++; if (modBit !== mmod) begin fails++; $display("FAIL rand_mod[%0d]: got %b want %b", i, modBit, mmod); end
      checks++; if (cif.cmdReady !== !mpend) begin fails++; $display("FAIL rand_ready[%0d]: got %b want %b", i, cif.cmdReady, !mpend); end
      checks++; if (cif.cmdApplied !== expApplied) begin fails++; $display("FAIL rand_applied[%0d]: got %b want %b", i, cif.cmdApplied, expApplied); end
    end
  endtask
  initial begin
    cif.cmdIn = '0; cif.invertBit = '0; cif.cmdValid = 0;
    test_reset();
    test_zero_input();
    test_half_scale();
    test_taps();
    test_cmd_hold();
    test_coincident();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
